if_prefetch: RTL and testbench

//  Parametrised instruction-fetch front end; next generation of pc_reg + if_id. Keeps up to DEPTH

---
 rtl/if_prefetch_pkg.sv | 23 ++
 rtl/if_fifo.sv | 78 +++++++
 rtl/if_prefetch.sv | 126 ++++++++++++
 tb/tb_if_prefetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_pkg.sv
// ============================================================================
// if_prefetch_pkg : shared types and helpers for the instruction prefetcher
// Rev 1.0
// ============================================================================
`default_nettype none

package if_prefetch_pkg;

  typedef enum logic [0:0] {
    IF_FETCH = 1'b0,
    IF_DRAIN = 1'b1
  } if_state_e;

  localparam int PC_STEP = 4;

  // Counter width able to hold 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fifo.sv
// ============================================================================
// if_fifo : synchronous FIFO with clear, registered head, wrap-bit pointers
// Rev 1.0
// ============================================================================
`default_nettype none

module if_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic [PTR_W-1:0] count_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full || do_pop);
    if (clear_i) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[IDX_W-1:0]] = push_data_i;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  // The credit rule upstream must never let a push land on a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push_i && full && !pop_i && !clear_i));

endmodule

`default_nettype wire

// File: rtl/if_prefetch.sv
// ============================================================================
// if_prefetch : credit-limited instruction prefetcher with redirect and drain
// Optional same-cycle ROM->ID bypass enabled by defining IF_BYPASS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_valid_i,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
);

  localparam int CNT_W = cnt_w(DEPTH);

  if_state_e         state_q, state_d;
  logic              run_q, run_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic [ADDR_W+DATA_W-1:0] fifo_head;
  logic                     fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_push;
  logic [CNT_W:0]           credit_used;
  logic                     issue;
  logic                     resp_keep;
  logic                     byp_take;

  // FIFO occupancy is taken before any pop, so credit is conservative.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign issue       = run_q && (state_q == IF_FETCH) && !redirect_i &&
                       (credit_used < (CNT_W+1)'(DEPTH));
  assign rom_ce_o    = issue;
  assign rom_addr_o  = fetch_pc_q;
  assign resp_keep   = rom_valid_i && (drop_q == '0) && !redirect_i;

`ifdef IF_BYPASS_EN
  assign byp_take     = fifo_empty && resp_keep && inst_ready_i;
  assign inst_valid_o = !fifo_empty || resp_keep;
  assign inst_pc_o    = (fifo_empty && resp_keep) ? resp_pc_q  : fifo_head[ADDR_W+DATA_W-1:DATA_W];
  assign inst_o       = (fifo_empty && resp_keep) ? rom_data_i : fifo_head[DATA_W-1:0];
`else
  assign byp_take     = 1'b0;
  assign inst_valid_o = !fifo_empty;
  assign inst_pc_o    = fifo_head[ADDR_W+DATA_W-1:DATA_W];
  assign inst_o       = fifo_head[DATA_W-1:0];
`endif

  assign fifo_push = resp_keep && !byp_take;

  if_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (redirect_i),
    .push_i      (fifo_push),
    .push_data_i ({resp_pc_q, rom_data_i}),
    .pop_i       (inst_ready_i && !redirect_i),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    run_d         = 1'b1;
    fetch_pc_d    = issue ? fetch_pc_q + ADDR_W'(PC_STEP) : fetch_pc_q;
    resp_pc_d     = resp_keep ? resp_pc_q + ADDR_W'(PC_STEP) : resp_pc_q;
    outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(rom_valid_i);
    drop_d        = drop_q;
    if (redirect_i) begin
      // Everything still in flight after this edge belongs to the old path.
      fetch_pc_d = redirect_pc_i;
      resp_pc_d  = redirect_pc_i;
      drop_d     = outstanding_d;
      state_d    = (outstanding_d != '0) ? IF_DRAIN : IF_FETCH;
    end else if (rom_valid_i && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
      if (drop_q == CNT_W'(1)) begin
        state_d = IF_FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IF_FETCH;
      run_q         <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_prefetch.sv
// ============================================================================
// tb_if_prefetch : directed bench for if_prefetch with a fixed-latency ROM model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_prefetch;

`ifdef IF_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  localparam int FILL = 3 - BYP;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_vld;
  logic [31:0] rom_data;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        rom_valid_g;

  logic        ce0, ce1, ivalid0, ivalid1;
  logic [31:0] addr0, addr1, inst0, inst1, ipc0, ipc1;

  int n_checks = 0;
  int n_errors = 0;
  int lat = 1;
  int rcyc = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t rq[$];

  always #5 clk = ~clk;

  // ROM drops its response immediately when reset is applied.
  assign rom_valid_g = rom_vld & ~rst;

  if_prefetch u_dut0 (
    .clk(clk), .rst(rst), .rom_ce_o(ce0), .rom_addr_o(addr0),
    .rom_valid_i(rom_valid_g), .rom_data_i(rom_data),
    .inst_valid_o(ivalid0), .inst_o(inst0), .inst_pc_o(ipc0),
    .inst_ready_i(inst_ready), .redirect_i(redirect), .redirect_pc_i(redirect_pc)
  );

  // Same handshake timing as u_dut0, different reset PC.
  if_prefetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut1 (
    .clk(clk), .rst(rst), .rom_ce_o(ce1), .rom_addr_o(addr1),
    .rom_valid_i(rom_valid_g), .rom_data_i(rom_data),
    .inst_valid_o(ivalid1), .inst_o(inst1), .inst_pc_o(ipc1),
    .inst_ready_i(inst_ready), .redirect_i(redirect), .redirect_pc_i(redirect_pc)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  initial begin
    rom_vld  = 1'b0;
    rom_data = '0;
    forever begin
      @(posedge clk);
      #1;
      rcyc++;
      if (rst) begin
        rq.delete();
        rom_vld  = 1'b0;
        rom_data = '0;
      end else if (rq.size() > 0 && rq[0].due <= rcyc) begin
        rom_vld  = 1'b1;
        rom_data = rom_word(rq[0].addr);
        void'(rq.pop_front());
      end else begin
        rom_vld  = 1'b0;
        rom_data = '0;
      end
      @(negedge clk);
      if (!rst && ce0) rq.push_back('{addr0, rcyc + lat});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  // Leaves the bench 2ns into cycle 0 with reset released.
  task automatic do_reset(input int l);
    rst      = 1'b1;
    redirect = 1'b0;
    lat      = l;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    // Reset state.
    tick();
    check_eq("rst_ce",      32'(ce0),     0);
    check_eq("rst_valid",   32'(ivalid0), 0);
    check_eq("rst_inst",    inst0,        0);
    check_eq("rst_pc",      ipc0,         0);
    check_eq("rst_addr",    addr0,        0);
    check_eq("rst_addr_hi", addr1,        32'hFFFF_FFF8);

    // Latency 1, always ready: streaming, plus wrap on the high reset PC.
    inst_ready = 1'b1;
    do_reset(1);
    settle();
    check_eq("t1_ce_c0", 32'(ce0), 0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      settle();
      if (c == 1) begin
        check_eq("t1_ce_c1",   32'(ce0), 1);
        check_eq("t1_addr_c1", addr0,    0);
        check_eq("t5_addr_c1", addr1,    32'hFFFF_FFF8);
      end
      if (c == 2) begin
        check_eq("t6_valid_c2", 32'(ivalid0), 32'(BYP));
        if (BYP == 1) check_eq("t6_byp_inst", inst0, rom_data);
      end
      if (c >= FILL) begin
        check_eq("t1_valid", 32'(ivalid0), 1);
        check_eq("t1_pc",    ipc0,         32'(4 * (c - FILL)));
        check_eq("t1_inst",  inst0,        rom_word(32'(4 * (c - FILL))));
        if (c < FILL + 4) check_eq("t5_pc_wrap", ipc1, 32'hFFFF_FFF8 + 32'(4 * (c - FILL)));
      end
    end

    // Asynchronous reset mid-stream.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_arst_ce",     32'(ce0),     0);
    check_eq("t5_arst_ce_hi",  32'(ce1),     0);
    check_eq("t5_arst_valid",  32'(ivalid0), 0);
    check_eq("t5_arst_vld_hi", 32'(ivalid1), 0);
    check_eq("t5_arst_inst",   inst0,        0);
    check_eq("t5_arst_pc",     ipc0,         0);
    check_eq("t5_arst_pc_hi",  ipc1,         0);
    check_eq("t5_arst_addr",   addr1,        32'hFFFF_FFF8);

    // Latency 3, not ready: credit limit and resume.
    inst_ready = 1'b0;
    do_reset(3);
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 10) inst_ready = 1'b1;
      settle();
      if (c == 1) check_eq("t5_restart", addr1, 32'hFFFF_FFF8);
      if (c <= 4) begin
        check_eq("t2_ce_on",  32'(ce0), 1);
        check_eq("t2_addr",   addr0,    32'(4 * (c - 1)));
      end else if (c <= 10) begin
        check_eq("t2_ce_off", 32'(ce0), 0);
      end
      if (c == 9) begin
        check_eq("t2_full_valid", 32'(ivalid0), 1);
        check_eq("t2_full_pc",    ipc0,         0);
      end
      if (c == 11) begin
        check_eq("t2_resume_ce",   32'(ce0), 1);
        check_eq("t2_resume_addr", addr0,    32'h10);
      end
      if (c >= 10) begin
        check_eq("t2_drain_pc",   ipc0,  32'(4 * (c - 10)));
        check_eq("t2_drain_inst", inst0, rom_word(32'(4 * (c - 10))));
      end
    end

    // Latency 3, redirect with two requests in flight.
    inst_ready = 1'b0;
    do_reset(3);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 3) begin
        redirect    = 1'b1;
        redirect_pc = 32'h100;
      end else begin
        redirect = 1'b0;
      end
      settle();
      if (c == 2) check_eq("t3_addr_c2", addr0, 4);
      if (c >= 3 && c <= 5) check_eq("t3_drain_ce", 32'(ce0), 0);
      if (c == 4 || c == 5) check_eq("t3_drop_valid", 32'(ivalid0), 0);
      if (c == 6) begin
        check_eq("t3_refetch_ce",   32'(ce0), 1);
        check_eq("t3_refetch_addr", addr0,    32'h100);
      end
      if (c == 7) check_eq("t3_addr_c7", addr0, 32'h104);
      if (c == 9) check_eq("t3_valid_c9", 32'(ivalid0), 32'(BYP));
      if (c == 10) begin
        check_eq("t3_valid", 32'(ivalid0), 1);
        check_eq("t3_pc",    ipc0,         32'h100);
        check_eq("t3_inst",  inst0,        rom_word(32'h100));
      end
    end

    // Latency 1, ready: redirect coincident with a response and a pop.
    inst_ready = 1'b1;
    do_reset(1);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 3) begin
        redirect    = 1'b1;
        redirect_pc = 32'h200;
      end else begin
        redirect = 1'b0;
      end
      settle();
      if (c == 3) begin
        check_eq("t4_ce_redirect", 32'(ce0),     0);
        check_eq("t4_valid_c3",    32'(ivalid0), 32'(1 - BYP));
      end
      if (c == 4) begin
        check_eq("t4_valid_c4", 32'(ivalid0), 0);
        check_eq("t4_ce_c4",    32'(ce0),     1);
        check_eq("t4_addr_c4",  addr0,        32'h200);
      end
      if (c == 5) check_eq("t4_valid_c5", 32'(ivalid0), 32'(BYP));
      if (c == 6) begin
        check_eq("t4_valid_c6", 32'(ivalid0), 1);
        check_eq("t4_pc_c6",    ipc0,         32'h200 + 32'(4 * BYP));
        check_eq("t4_inst_c6",  inst0,        rom_word(32'h200 + 32'(4 * BYP)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
